// File: rtl/cmd_issuer_pkg.sv
// cmd_pkg: shared constants for the ALU command issuer.
// Contents: opcode values, bit positions of each field in the command byte,
// entry stage encodings, reject reason codes and a byte-packing helper.
package cmd_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    localparam int OP_POS  = 6;
    localparam int N1_POS  = 4;
    localparam int N2_POS  = 2;
    localparam int RID_POS = 0;
    typedef enum logic [1:0] {S_OP = 2'd0, S_N1 = 2'd1, S_N2 = 2'd2, S_RID = 2'd3} stage_t;
    localparam logic [1:0] REJ_NONE = 2'b00;
    localparam logic [1:0] REJ_DIV0 = 2'b01;
    localparam logic [1:0] REJ_FULL = 2'b10;
    function automatic logic [7:0] pack_cmd(logic [1:0] op, logic [1:0] n1, logic [1:0] n2, logic [1:0] rid);
        logic [7:0] c;
        c = 8'h00;
        c[OP_POS +: 2]  = op;
        c[N1_POS +: 2]  = n1;
        c[N2_POS +: 2]  = n2;
        c[RID_POS +: 2] = rid;
        return c;
    endfunction
endpackage

// File: rtl/cmd_issuer_if.sv
// cmd_issuer_if: operator-side field entry and downstream command handshake.
// master drives field_in/field_stb/abort/cmd_ready; slave (cmd_issuer) drives
// cmd_out/cmd_valid/stage_out/reject/rej_code/count_out.
interface cmd_issuer_if #(parameter int CNT_W = 3);
    logic [1:0]       field_in;
    logic             field_stb;
    logic             abort;
    logic [7:0]       cmd_out;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       stage_out;
    logic             reject;
    logic [1:0]       rej_code;
    logic [CNT_W-1:0] count_out;
    modport master (
        output field_in, field_stb, abort, cmd_ready,
        input  cmd_out, cmd_valid, stage_out, reject, rej_code, count_out
    );
    modport slave (
        input  field_in, field_stb, abort, cmd_ready,
        output cmd_out, cmd_valid, stage_out, reject, rej_code, count_out
    );
endinterface

// File: rtl/cmd_issuer_fifo.sv
// cmd_fifo: show-ahead synchronous FIFO, DEPTH x 8.
// Ports: clk, rst (async, active-high), push/din write, pop read,
// dout head byte (00 when empty), empty, full, count occupancy.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       din,
    input  logic             pop,
    output logic [7:0]       dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;
    assign empty  = r_count == '0;
    assign full   = r_count == CNT_W'(DEPTH);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = empty ? 8'h00 : r_mem[r_rd];
    assign count  = r_count;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_rd    <= r_rd + PTR_W'(w_pop);
            r_wr    <= r_wr + PTR_W'(w_push);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end
endmodule

// File: rtl/cmd_issuer.sv
// cmd_issuer: assembles 2-bit fields into ALU command bytes and queues them.
// Ports: clk, rst (async, active-high), bus (cmd_issuer_if.slave) carrying
// field entry, abort, the cmd valid/ready handshake, stage, reject status and occupancy.
module cmd_issuer
    import cmd_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    cmd_issuer_if.slave  bus
);
    stage_t     r_state;
    stage_t     w_next;
    logic [1:0] r_op;
    logic [1:0] r_n1;
    logic [1:0] r_n2;
    logic       r_reject;
    logic [1:0] r_rej_code;
    logic       w_take;
    logic       w_done;
    logic       w_div0;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_rej;
    logic [7:0] w_byte;
    always_comb begin
        w_take = bus.field_stb & ~bus.abort;
        w_next = bus.abort ? S_OP : (w_take ? stage_t'(r_state + 2'd1) : r_state);
        w_done = w_take & (r_state == S_RID);
        w_div0 = (r_op == OP_DIV) & (r_n2 == 2'b00);
        // full is judged on the pre-edge count, so a same-cycle pop cannot make room
        w_push = w_done & ~w_div0 & ~w_full;
        w_rej  = w_done & (w_div0 | w_full);
        w_byte = pack_cmd(r_op, r_n1, r_n2, bus.field_in);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_OP;
            r_op       <= 2'b00;
            r_n1       <= 2'b00;
            r_n2       <= 2'b00;
            r_reject   <= 1'b0;
            r_rej_code <= REJ_NONE;
        end else begin
            r_state    <= w_next;
            r_op       <= (w_take && r_state == S_OP) ? bus.field_in : r_op;
            r_n1       <= (w_take && r_state == S_N1) ? bus.field_in : r_n1;
            r_n2       <= (w_take && r_state == S_N2) ? bus.field_in : r_n2;
            r_reject   <= w_rej;
            r_rej_code <= w_rej ? (w_div0 ? REJ_DIV0 : REJ_FULL) : r_rej_code;
        end
    end
    cmd_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_byte),
        .pop   (bus.cmd_valid & bus.cmd_ready),
        .dout  (bus.cmd_out),
        .empty (w_empty),
        .full  (w_full),
        .count (bus.count_out)
    );
    assign bus.cmd_valid = ~w_empty;
    assign bus.stage_out = r_state;
    assign bus.reject    = r_reject;
    assign bus.rej_code  = r_rej_code;
endmodule

// File: tb/tb_cmd_issuer.sv
// tb_cmd_issuer: directed and random stimulus against a queue-based reference model.
module tb_cmd_issuer;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    cmd_issuer_if #(.CNT_W(CNT_W)) bus ();
    cmd_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int failures = 0;
    logic [7:0] q[$];
    int         m_stage;
    logic [1:0] m_f[3];
    logic       m_rej;
    logic [1:0] m_code;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask
    task automatic compare();
        chk("stage", 32'(bus.stage_out), 32'(m_stage));
        chk("valid", 32'(bus.cmd_valid), 32'(q.size() > 0));
        chk("cmd_out", 32'(bus.cmd_out), q.size() > 0 ? 32'(q[0]) : 32'h0);
        chk("count", 32'(bus.count_out), 32'(q.size()));
        chk("reject", 32'(bus.reject), 32'(m_rej));
        chk("rej_code", 32'(bus.rej_code), 32'(m_code));
    endtask
    task automatic model_reset();
        q.delete();
        m_stage = 0;
        m_rej = 1'b0;
        m_code = 2'b00;
    endtask
    task automatic step(input logic s, input logic [1:0] f, input logic a, input logic r);
        logic       pop;
        logic       push;
        logic [7:0] b;
        bus.field_stb = s;
        bus.field_in  = f;
        bus.abort     = a;
        bus.cmd_ready = r;
        @(posedge clk);
        pop = (q.size() > 0) && r;
        push = 1'b0;
        m_rej = 1'b0;
        b = 8'h00;
        if (a) m_stage = 0;
        else if (s) begin
            if (m_stage < 3) begin
                m_f[m_stage] = f;
                m_stage++;
            end else begin
                b = {m_f[0], m_f[1], m_f[2], f};
                m_stage = 0;
                if (m_f[0] == 2'b11 && m_f[2] == 2'b00) begin
                    m_rej = 1'b1;
                    m_code = 2'b01;
                end else if (q.size() == DEPTH) begin
                    m_rej = 1'b1;
                    m_code = 2'b10;
                end else push = 1'b1;
            end
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back(b);
        #1;
        compare();
    endtask
    task automatic enter(input logic [7:0] b, input logic r);
        for (int i = 0; i < 4; i++) step(1'b1, b[7-2*i -: 2], 1'b0, r);
    endtask
    initial begin
        bus.field_stb = 1'b0;
        bus.field_in  = 2'b00;
        bus.abort     = 1'b0;
        bus.cmd_ready = 1'b0;
        model_reset();
        #2 compare();
        @(posedge clk);
        #2 rst = 1'b0;
        enter(8'h1B, 1'b0);
        chk("first_byte", 32'(bus.cmd_out), 32'h1B);
        chk("first_cnt", 32'(bus.count_out), 32'd1);
        enter(8'hE1, 1'b0);
        chk("div0_code", 32'(bus.rej_code), 32'd1);
        step(1'b0, 2'b00, 1'b0, 1'b0);
        chk("rej_pulse_end", 32'(bus.reject), 32'd0);
        enter(8'h55, 1'b0);
        enter(8'h9A, 1'b0);
        enter(8'hE7, 1'b0);
        enter(8'h00, 1'b0);
        chk("full_code", 32'(bus.rej_code), 32'd2);
        chk("full_cnt", 32'(bus.count_out), 32'd4);
        for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 1'b0, 1'b1);
        chk("drained", 32'(bus.cmd_valid), 32'd0);
        step(1'b1, 2'b00, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        step(1'b1, 2'b01, 1'b1, 1'b0);
        chk("abort_stage", 32'(bus.stage_out), 32'd0);
        enter(8'h24, 1'b0);
        chk("after_abort", 32'(bus.cmd_out), 32'h24);
        enter(8'h11, 1'b0);
        enter(8'h22, 1'b0);
        enter(8'h33, 1'b0);
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b01, 1'b0, 1'b1);
        chk("full_pop_cnt", 32'(bus.count_out), 32'd3);
        chk("full_pop_code", 32'(bus.rej_code), 32'd2);
        step(1'b1, 2'b01, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("rst_stage", 32'(bus.stage_out), 32'd0);
        chk("rst_valid", 32'(bus.cmd_valid), 32'd0);
        chk("rst_cnt", 32'(bus.count_out), 32'd0);
        chk("rst_out", 32'(bus.cmd_out), 32'd0);
        chk("rst_code", 32'(bus.rej_code), 32'd0);
        model_reset();
        #1 rst = 1'b0;
        repeat (3000)
            step($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cmd_issuer.md
Name: cmd_issuer

Overview:
- Front end that builds 8-bit ALU command bytes for the command parser: opcode[7:6], num1[5:4], num2[3:2], reg_id[1:0].
- Operator supplies one 2-bit field per strobe, in fixed order. A field-collection FSM assembles the byte and rejects illegal commands; a small FIFO then issues bytes downstream over a valid/ready handshake.
- Sits between the switch/button input logic and the parser's cmd_in. When the consumer has no back-pressure, cmd_ready is tied high.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- field_in  in  2  field value, sampled when field_stb=1.
- field_stb  in  1  single-cycle strobe; accept field_in into the current field.
- abort  in  1  discard the partially entered command.
- cmd_out  out  8  command byte at FIFO head (show-ahead).
- cmd_valid  out  1  FIFO non-empty.
- cmd_ready  in  1  consumer accepts cmd_out this cycle.
- stage_out  out  2  field expected next: 0=opcode, 1=num1, 2=num2, 3=reg_id.
- reject  out  1  one-cycle pulse; assembled command dropped.
- rej_code  out  2  reason, held until next reject or reset: 01=divide by zero, 10=FIFO full.
- count_out  out  CNT_W  FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst=1):
  - FSM to S_OP; FIFO emptied (rd/wr pointers and count = 0).
  - cmd_out=8'h00, cmd_valid=0, stage_out=0, reject=0, rej_code=00, count_out=0.
- FSM states: S_OP -> S_N1 -> S_N2 -> S_RID -> S_OP.
  - Each state advances on field_stb=1 and latches field_in into its own field register.
  - stage_out encodes the state directly.
- Completion (field_stb=1 in S_RID):
  - Byte = {op, n1, n2, field_in}.
  - If op=2'b11 and n2=2'b00: no push, reject=1, rej_code=01.
  - Else if count=DEPTH: no push, reject=1, rej_code=10.
  - Else: push.
  - FSM returns to S_OP in every case.
  - Divide-by-zero has priority over full.
- abort=1 in any state: FSM to S_OP, field registers unchanged (don't-care), no push, no reject.
  - abort together with field_stb: abort wins; the strobe is ignored.
- field_stb held high across several cycles: one field is consumed per cycle. Edge detection is upstream's job.
- FIFO:
  - Show-ahead: cmd_out = mem[rd_ptr], and is 8'h00 when empty.
  - Pop when cmd_valid & cmd_ready.
  - Push-to-visible latency is 1 cycle: a byte pushed at edge N appears on cmd_out with cmd_valid=1 after edge N.
  - Push and pop in the same cycle: both occur, count unchanged.
  - Full test uses the pre-edge count: a push while full is rejected even if a pop occurs that same cycle.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - cmd_ready while empty: no effect; count never underflows.
- Opcodes are passed through unmodified. Only the divide-by-zero case is filtered, matching the parser's error condition.
- Reset asserted mid-entry or mid-drain: partial command and all queued bytes are lost; outputs return to reset values immediately.

Decomposition:
- Shared package (cmd_pkg):
  - Opcode constants OP_ADD=00, OP_SUB=01, OP_MUL=10, OP_DIV=11.
  - Field bit positions.
  - Stage encodings S_OP..S_RID.
  - Reject codes REJ_NONE=00, REJ_DIV0=01, REJ_FULL=10.
- One natural sub-module: cmd_fifo.
  - Parameterised sync FIFO, DEPTH x 8.
  - Ports: clk, rst, push, din, pop, dout, empty, full, count.
  - cmd_issuer keeps the FSM and reject logic.

Test Plan:
- Reset then strobes 00,01,10,11 (ADD 1+2 -> r3) with cmd_ready=0 -> stage_out steps 0,1,2,3,0; cmd_out=8'h1B and cmd_valid=1 one cycle after the 4th strobe; count_out=1.
- Strobes 11,10,00,01 (DIV 2/0) -> reject pulse for 1 cycle, rej_code=01, count_out unchanged, cmd_valid unchanged.
- cmd_ready=0, enter 5 valid commands (DEPTH=4): bytes 8'h1B, 8'h55, 8'h9A, 8'hE7, 8'h00 -> first four queued, count_out=4, 5th rejects with rej_code=10. Then cmd_ready=1 -> outputs 1B, 55, 9A, E7 on consecutive cycles, then cmd_valid=0.
- Two fields entered, then abort=1 together with field_stb -> stage_out=0, no push, no reject; next full entry of 8'h24 queues normally.
- FIFO full, cmd_ready=1, completing push in the same cycle -> pop happens, push rejected (rej_code=10), count_out becomes 3.
- rst asserted mid-entry (stage 2) with 3 queued -> asynchronously stage_out=0, cmd_valid=0, count_out=0, cmd_out=8'h00, rej_code=00.
